// File: rtl/game_pkg.sv
// Shared game constants: button codes (the same ones the rectangle blocks
// decode), screen geometry, player size and the movement FSM state type.
package game_pkg;

   localparam logic [3:0] BTN_UP    = 4'd8;
   localparam logic [3:0] BTN_DOWN  = 4'd4;
   localparam logic [3:0] BTN_RIGHT = 4'd2;
   localparam logic [3:0] BTN_LEFT  = 4'd1;

   localparam int SCREEN_H    = 640;
   localparam int SCREEN_V    = 480;
   localparam int PLAYER_SIZE = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } mv_state_e;

   // Exactly one direction button; multi-button values count as released.
   function automatic logic is_valid_btn(input logic [3:0] b);
      return (b == BTN_UP) || (b == BTN_DOWN) || (b == BTN_RIGHT) || (b == BTN_LEFT);
   endfunction

endpackage

// File: rtl/btn_repeat_fsm.sv
// Hold-to-repeat button FSM.
//   state  | meaning
//   IDLE   | no direction held; a valid press steps immediately
//   DELAY  | first step done, waiting REPEAT_DELAY cycles for auto-repeat
//   REPEAT | auto-repeat, one step every REPEAT_PERIOD cycles
// Ports: clk_i, rst_i (sync, active-high), btns_i (button bus),
//        step_o (step on this edge), dir_o (direction of that step),
//        moving_o (registered, state != IDLE).
module btn_repeat_fsm
   import game_pkg::*;
#(
   parameter int REPEAT_DELAY  = 8,
   parameter int REPEAT_PERIOD = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] btns_i,
   output logic       step_o,
   output logic [3:0] dir_o,
   output logic       moving_o
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_DELAY  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_PERIOD = CNT_W'(REPEAT_PERIOD - 1);

   mv_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       dir_q, dir_d;
   logic             moving_q;

   // Step strobe is combinational so the datapath moves on the same edge
   // that samples the press; the top's outputs are all registered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      step_o  = 1'b0;
      dir_o   = dir_q;
      case (state_q)
         IDLE: begin
            if (is_valid_btn(btns_i)) begin
               step_o  = 1'b1;
               dir_o   = btns_i;
               dir_d   = btns_i;
               cnt_d   = CNT_DELAY;
               state_d = DELAY;
            end
         end
         DELAY, REPEAT: begin
            if (btns_i != dir_q) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               step_o  = 1'b1;
               cnt_d   = CNT_PERIOD;
               state_d = REPEAT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dir_q    <= '0;
         moving_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         moving_q <= (state_d != IDLE);
      end
   end

   assign moving_o = moving_q;

endmodule

// File: rtl/player_controller.sv
// Player position / colour owner. Hold-to-repeat movement with enable
// gating and screen-edge clamping, plus edge-triggered colour cycling.
// Ports: btnClk, rst (sync, active-high), btns, color_btn,
//        up/down/left/rightEnable (move permits from the rectangles),
//        player_hPos, player_vPos, player_color, moving, blocked.
module player_controller #(
   parameter int H_RES         = 640,
   parameter int V_RES         = 480,
   parameter int PLAYER_SIZE   = 12,
   parameter int STEP          = 1,
   parameter int REPEAT_DELAY  = 8,
   parameter int REPEAT_PERIOD = 2,
   parameter int H_START       = 0,
   parameter int V_START       = 0,
   parameter int COLOR_INIT    = 0
) (
   input  logic        btnClk,
   input  logic        rst,
   input  logic [3:0]  btns,
   input  logic        color_btn,
   input  logic        upEnable,
   input  logic        downEnable,
   input  logic        leftEnable,
   input  logic        rightEnable,
   output logic [31:0] player_hPos,
   output logic [31:0] player_vPos,
   output logic [3:0]  player_color,
   output logic        moving,
   output logic        blocked
);
   import game_pkg::*;

   localparam logic [31:0] H_LIM  = 32'(H_RES - PLAYER_SIZE);
   localparam logic [31:0] V_LIM  = 32'(V_RES - PLAYER_SIZE);
   localparam logic [31:0] STEP_W = 32'(STEP);

   logic [31:0] hpos_q, hpos_d;
   logic [31:0] vpos_q, vpos_d;
   logic [3:0]  color_q, color_d;
   logic        color_prev_q;
   logic        blocked_q, blocked_d;
   logic        step;
   logic [3:0]  step_dir;
   logic        moving_w;

   btn_repeat_fsm #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
   ) u_fsm (
      .clk_i   (btnClk),
      .rst_i   (rst),
      .btns_i  (btns),
      .step_o  (step),
      .dir_o   (step_dir),
      .moving_o(moving_w)
   );

   // blocked flags a step that was disabled or produced no motion at an edge.
   always_comb begin
      hpos_d    = hpos_q;
      vpos_d    = vpos_q;
      blocked_d = 1'b0;
      if (step) begin
         case (step_dir)
            BTN_UP: begin
               if (!upEnable)             blocked_d = 1'b1;
               else if (vpos_q >= STEP_W) vpos_d = vpos_q - STEP_W;
               else begin
                  vpos_d    = '0;
                  blocked_d = (vpos_q == '0);
               end
            end
            BTN_DOWN: begin
               if (!downEnable)                  blocked_d = 1'b1;
               else if (vpos_q + STEP_W <= V_LIM) vpos_d = vpos_q + STEP_W;
               else begin
                  vpos_d    = V_LIM;
                  blocked_d = (vpos_q == V_LIM);
               end
            end
            BTN_LEFT: begin
               if (!leftEnable)           blocked_d = 1'b1;
               else if (hpos_q >= STEP_W) hpos_d = hpos_q - STEP_W;
               else begin
                  hpos_d    = '0;
                  blocked_d = (hpos_q == '0);
               end
            end
            BTN_RIGHT: begin
               if (!rightEnable)                 blocked_d = 1'b1;
               else if (hpos_q + STEP_W <= H_LIM) hpos_d = hpos_q + STEP_W;
               else begin
                  hpos_d    = H_LIM;
                  blocked_d = (hpos_q == H_LIM);
               end
            end
            default: blocked_d = 1'b0;
         endcase
      end
      color_d = (color_btn && !color_prev_q) ? color_q + 4'd1 : color_q;
   end

   always_ff @(posedge btnClk) begin
      if (rst) begin
         hpos_q       <= 32'(H_START);
         vpos_q       <= 32'(V_START);
         color_q      <= 4'(COLOR_INIT);
         color_prev_q <= 1'b0;
         blocked_q    <= 1'b0;
      end else begin
         hpos_q       <= hpos_d;
         vpos_q       <= vpos_d;
         color_q      <= color_d;
         color_prev_q <= color_btn;
         blocked_q    <= blocked_d;
      end
   end

   assign player_hPos  = hpos_q;
   assign player_vPos  = vpos_q;
   assign player_color = color_q;
   assign moving       = moving_w;
   assign blocked      = blocked_q;

endmodule
